// File: rtl/xtap_pkg.sv
// Shared constants and helper functions for the xtap_bus slice.
package xtap_pkg;

  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 16;

  // Width of a tap index for a pipeline of the given depth (never below 1).
  function automatic int selw_f(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // One-hot decode of a tap index; indices at or beyond depth give all zeros.
  function automatic logic [DEPTH_MAX-1:0] onehot_f(input int unsigned idx,
                                                     input int unsigned depth);
    logic [DEPTH_MAX-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < DEPTH_MAX; k++) begin
      r[k] = (idx == k) && (k < depth);
    end
    return r;
  endfunction

  // Number of set bits in a tap vector.
  function automatic int unsigned popcount_f(input logic [DEPTH_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int k = 0; k < DEPTH_MAX; k++) begin
      if (v[k]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/xtap_drv.sv
// Single W-bit tri-state buffer: drives i onto o while en is high, else Z.
module xtap_drv #(
  parameter int W = 8
) (
  input  logic [W-1:0] i,
  input  logic         en,
  output tri   [W-1:0] o
);

  assign o = en ? i : {W{1'bz}};

endmodule

// File: rtl/xtap_bus.sv
// Multi-tap shift pipeline driving a shared tri-state bus, with contention
// detection and a saturating contention-cycle counter.
module xtap_bus
  import xtap_pkg::*;
#(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  parameter  int CNTW  = 8,
  localparam int SELW  = selw_f(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic [W-1:0]     d,
  input  logic             sel_we,
  input  logic [SELW-1:0]  sel,
  input  logic             multi,
  input  logic [DEPTH-1:0] mask,
  input  logic             clr_cnt,
  output tri   [W-1:0]     bus,
  output logic [DEPTH-1:0] en_q,
  output logic [DEPTH-1:0] vld_q,
  output logic             bus_idle,
  output logic             contention,
  output logic [CNTW-1:0]  cont_cnt
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [W-1:0]         stage [DEPTH];
  logic [DEPTH-1:0]     act;
  logic [DEPTH_MAX-1:0] sel_oh;
  logic [DEPTH-1:0]     en_d;
  int unsigned          ndrv;
  logic                 multi_drv;

  // Shift data and valid bits toward the last tap on each shift_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
      vld_q <= '0;
    end else if (shift_en) begin
      stage[0] <= d;
      for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
      vld_q <= {vld_q[DEPTH-2:0], 1'b1};
    end
  end

  // Next tap-enable pattern: raw mask for deliberate multi-drive, else one-hot.
  always_comb begin
    sel_oh = onehot_f(32'(sel), 32'(DEPTH));
    en_d   = multi ? mask : sel_oh[DEPTH-1:0];
  end

  // Tap-enable register, written only on sel_we.
  always_ff @(posedge clk) begin
    if (rst)         en_q <= '0;
    else if (sel_we) en_q <= en_d;
  end

  // A tap drives only once its stage holds shifted data and it is enabled.
  always_comb begin
    act       = en_q & vld_q;
    ndrv      = popcount_f(DEPTH_MAX'(act));
    bus_idle  = (ndrv == 0);
    multi_drv = (ndrv > 1);
  end

  // Contention flag and saturating counter, both one cycle behind the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      contention <= 1'b0;
      cont_cnt   <= '0;
    end else begin
      contention <= multi_drv;
      if (clr_cnt)                             cont_cnt <= '0;
      else if (multi_drv && cont_cnt != CNT_MAX) cont_cnt <= cont_cnt + CNTW'(1);
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_tap
    xtap_drv #(.W(W)) u_drv (
      .i  (stage[k]),
      .en (act[k]),
      .o  (bus)
    );
  end

endmodule

// File: tb/tb_xtap_bus.sv
// Directed bench for xtap_bus with a queue-based reference model checked
// shortly after every rising edge.
module tb_xtap_bus;

  localparam int W     = 8;
  localparam int DEPTH = 5;
  localparam int CNTW  = 2;
  localparam int SELW  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             shift_en;
  logic [W-1:0]     d;
  logic             sel_we;
  logic [SELW-1:0]  sel;
  logic             multi;
  logic [DEPTH-1:0] mask;
  logic             clr_cnt;
  tri   [W-1:0]     bus;
  logic [DEPTH-1:0] en_q;
  logic [DEPTH-1:0] vld_q;
  logic             bus_idle;
  logic             contention;
  logic [CNTW-1:0]  cont_cnt;

  int checks = 0;
  int errors = 0;

  xtap_bus #(.W(W), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst        (rst),
    .shift_en   (shift_en),
    .d          (d),
    .sel_we     (sel_we),
    .sel        (sel),
    .multi      (multi),
    .mask       (mask),
    .clr_cnt    (clr_cnt),
    .bus        (bus),
    .en_q       (en_q),
    .vld_q      (vld_q),
    .bus_idle   (bus_idle),
    .contention (contention),
    .cont_cnt   (cont_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: data history as a queue (newest first), shift count
  // for validity, enable pattern, contention flag and counter as integers.
  logic [W-1:0]     hist[$];
  int               nsh;
  logic [DEPTH-1:0] m_en;
  logic             m_cont;
  int               m_cnt;
  bit               model_on = 0;

  function automatic logic [DEPTH-1:0] m_vld();
    logic [DEPTH-1:0] v;
    for (int k = 0; k < DEPTH; k++) v[k] = (nsh > k);
    return v;
  endfunction

  function automatic int m_ndrv();
    return $countones(m_en & m_vld());
  endfunction

  always begin
    int prev;
    logic [DEPTH-1:0] a;
    @(posedge clk);
    prev = m_ndrv();
    if (rst) begin
      hist.delete();
      nsh      = 0;
      m_en     = '0;
      m_cont   = 1'b0;
      m_cnt    = 0;
      model_on = 1;
    end else if (model_on) begin
      if (shift_en) begin
        hist.push_front(d);
        if (hist.size() > DEPTH) void'(hist.pop_back());
        nsh++;
      end
      if (sel_we) begin
        m_en = '0;
        if (multi) m_en = mask;
        else if (int'(sel) < DEPTH) m_en[sel] = 1'b1;
      end
      m_cont = (prev > 1);
      if (clr_cnt) m_cnt = 0;
      else if (prev > 1 && m_cnt < (1 << CNTW) - 1) m_cnt++;
    end
    #1;
    if (model_on) begin
      chk("en_q", 32'(en_q), 32'(m_en));
      chk("vld_q", 32'(vld_q), 32'(m_vld()));
      chk("bus_idle", 32'(bus_idle), 32'(m_ndrv() == 0));
      chk("contention", 32'(contention), 32'(m_cont));
      chk("cont_cnt", 32'(cont_cnt), 32'(m_cnt));
      if (m_ndrv() == 1) begin
        a = m_en & m_vld();
        for (int k = 0; k < DEPTH; k++)
          if (a[k]) chk("bus", 32'(bus), 32'(hist[k]));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_sel(input logic [SELW-1:0] s);
    sel_we = 1'b1; multi = 1'b0; sel = s;
    tick();
    sel_we = 1'b0;
  endtask

  task automatic write_mask(input logic [DEPTH-1:0] m);
    sel_we = 1'b1; multi = 1'b1; mask = m;
    tick();
    sel_we = 1'b0; multi = 1'b0;
  endtask

  task automatic shift(input logic [W-1:0] v);
    shift_en = 1'b1; d = v;
    tick();
    shift_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; shift_en = 1'b0; d = '0; sel_we = 1'b0; sel = '0;
    multi = 1'b0; mask = '0; clr_cnt = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_vld", 32'(vld_q), 32'h0);
    chk("reset_idle", 32'(bus_idle), 32'h1);

    // Tap 2 enabled, three shifts: idle until the third one lands.
    write_sel(3'd2);
    shift(8'hA1);
    shift(8'hB2);
    chk("t1_idle_after_2", 32'(bus_idle), 32'h1);
    shift(8'hC3);
    chk("t1_bus_A1", 32'(bus), 32'hA1);
    chk("t1_no_cont", 32'(contention), 32'h0);

    // Out-of-range index clears all enables.
    write_sel(3'd5);
    chk("t2_en_zero", 32'(en_q), 32'h0);
    chk("t2_idle", 32'(bus_idle), 32'h1);
    write_sel(3'd7);

    // Fill the pipe, then drive two taps at once.
    shift(8'h11); shift(8'h22); shift(8'h33); shift(8'h44); shift(8'h55);
    chk("t3_full", 32'(vld_q), 32'h1F);
    write_mask(5'b00011);
    tick();
    chk("t3_cont_set", 32'(contention), 32'h1);
    chk("t3_cnt1", 32'(cont_cnt), 32'h1);
    tick(); tick(); tick(); tick();
    chk("t3_cnt_sat", 32'(cont_cnt), 32'h3);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("t3_cnt_clr", 32'(cont_cnt), 32'h0);
    write_mask(5'b00001);
    tick();
    chk("t3_cont_off", 32'(contention), 32'h0);
    chk("t3_bus_55", 32'(bus), 32'h55);
    tick();

    // Hold with tap 3 enabled: bus keeps stage 3 value.
    write_sel(3'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_hold_bus", 32'(bus), 32'h22);
      chk("t4_hold_vld", 32'(vld_q), 32'h1F);
    end

    // Simultaneous shift and enable write use post-edge values.
    shift_en = 1'b1; d = 8'h77; sel_we = 1'b1; sel = 3'd1;
    tick();
    shift_en = 1'b0; sel_we = 1'b0;
    chk("t5_simul_bus", 32'(bus), 32'h55);

    // Reset mid-stream overrides shift and enable writes.
    write_mask(5'b00110);
    tick();
    rst = 1'b1; shift_en = 1'b1; sel_we = 1'b1; sel = 3'd0; clr_cnt = 1'b0;
    tick();
    rst = 1'b0; shift_en = 1'b0; sel_we = 1'b0;
    chk("t6_vld", 32'(vld_q), 32'h0);
    chk("t6_en", 32'(en_q), 32'h0);
    chk("t6_idle", 32'(bus_idle), 32'h1);
    chk("t6_cont", 32'(contention), 32'h0);
    chk("t6_cnt", 32'(cont_cnt), 32'h0);

    // Last tap needs DEPTH shifts after reset before it drives.
    write_sel(3'd4);
    shift(8'h01); shift(8'h02); shift(8'h03); shift(8'h04);
    chk("t7_idle", 32'(bus_idle), 32'h1);
    shift(8'h05);
    chk("t7_bus", 32'(bus), 32'h01);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
